// File: rtl/bitty_ctrl_pkg.sv
// Shared types and constants for the bitty execution controller.
// Pure declarations: no latency, no flow control.
package bitty_ctrl_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int COUNT_W     = 16;
    localparam int WDOG_W      = 8;
    localparam int LAT_W       = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bitty_exec_watchdog.sv
// Counts EXEC cycles without a done and flags the cycle on which TIMEOUT is reached.
// expired_o is combinational from the count; no flow control.
module bitty_exec_watchdog
    import bitty_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The increment that would land on TIMEOUT is the expiring cycle.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/bitty_exec_ctrl.sv
// Fetch/issue/retire sequencer: owns the PC, latches instructions, pulses cpu_run, waits for done.
// 3 + MEM_LAT cycles per instruction minimum; stalls in EXEC until cpu_done or watchdog expiry.
module bitty_exec_ctrl
    import bitty_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic               halt_req,
    input  logic               clr_err,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  new_pc_in,
    input  logic               cpu_done,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic [INSTR_W-1:0] cpu_instr,
    output logic               cpu_run,
    output logic               busy,
    output logic               halted,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               run_q, run_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               wd_en, wd_clr, wd_expired;

    assign wd_clr = (state_q == S_ISSUE);
    assign wd_en  = (state_q == S_EXEC) && !cpu_done;

    bitty_exec_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if ((!step_mode && start) || (step_mode && step)) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    instr_d = instr_in;
                    lat_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_ISSUE: state_d = S_EXEC;
            S_EXEC: begin
                // Done is checked first so a done on the expiring cycle still retires.
                if (cpu_done) begin
                    state_d = S_UPDATE;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_UPDATE: begin
                pc_d  = new_pc_in;
                cnt_d = sat_inc(cnt_q);
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (step_mode) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (clr_err) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        run_d    = (state_d == S_ISSUE);
        busy_d   = state_d inside {S_FETCH, S_ISSUE, S_EXEC, S_UPDATE};
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            lat_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            lat_q    <= lat_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign pc_addr     = pc_q;
    assign cpu_instr   = instr_q;
    assign cpu_run     = run_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign timeout_err = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_bitty_exec_ctrl.sv
// Bench for bitty_exec_ctrl: random free run plus directed step, branch, halt, reset and watchdog scenarios.
module tb_bitty_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, step_mode, step, halt_req, clr_err, cpu_done;
    logic [15:0] instr_in;
    logic [7:0]  new_pc_in;
    logic [7:0]  pc_addr;
    logic [15:0] cpu_instr;
    logic        cpu_run, busy, halted, timeout_err;
    logic [15:0] instr_count;

    logic [15:0] imem [256];
    int          total = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [7:0]  exp_pc;
    logic [15:0] exp_count;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Zero-latency instruction memory; the controller samples on the last FETCH cycle.
    assign instr_in = imem[pc_addr];

    bitty_exec_ctrl #(
        .ADDR_W  (8),
        .INSTR_W (16),
        .MEM_LAT (1),
        .TIMEOUT (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .halt_req    (halt_req),
        .clr_err     (clr_err),
        .instr_in    (instr_in),
        .new_pc_in   (new_pc_in),
        .cpu_done    (cpu_done),
        .pc_addr     (pc_addr),
        .cpu_instr   (cpu_instr),
        .cpu_run     (cpu_run),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    task automatic wait_run(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_run === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Called on the ISSUE negedge; returns on the UPDATE negedge.
    task automatic finish_instr(input int d, input logic [7:0] npc);
        @(negedge clk);
        repeat (d) @(negedge clk);
        cpu_done  = 1'b1;
        new_pc_in = npc;
        @(negedge clk);
        cpu_done  = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if ({pc_addr, cpu_instr, cpu_run, busy, halted, timeout_err, instr_count} !== '0) begin
            fails++; $display("FAIL reset_state: got pc=%h instr=%h run=%b busy=%b halt=%b err=%b cnt=%h expected all zero",
                              pc_addr, cpu_instr, cpu_run, busy, halted, timeout_err, instr_count);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || cpu_run !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset: got busy=%b run=%b expected 0 0", busy, cpu_run);
        end
    endtask

    task automatic test_free_run;
        bit         seen;
        int         d, prev_d, t_prev;
        logic [7:0] npc;
        prev_d = 0; t_prev = 0;
        start = 1'b1; step_mode = 1'b0;
        for (int n = 0; n < 16; n++) begin
            wait_run(seen);
            total++; if (!seen) begin fails++; $display("FAIL free_run_pulse: no cpu_run for instr %0d", n); end
            total++; if (pc_addr !== exp_pc) begin
                fails++; $display("FAIL free_run_pc: got %h expected %h", pc_addr, exp_pc);
            end
            total++; if (cpu_instr !== imem[exp_pc]) begin
                fails++; $display("FAIL free_run_instr: got %h expected %h", cpu_instr, imem[exp_pc]);
            end
            total++; if (instr_count !== exp_count) begin
                fails++; $display("FAIL free_run_count: got %0d expected %0d", instr_count, exp_count);
            end
            if (n > 0) begin
                total++; if (cyc - t_prev != 4 + prev_d) begin
                    fails++; $display("FAIL free_run_period: got %0d expected %0d", cyc - t_prev, 4 + prev_d);
                end
            end
            t_prev = cyc;
            d      = $urandom_range(0, 4);
            npc    = (n == 15) ? 8'hA5 : 8'($urandom);
            finish_instr(d, npc);
            if (n == 15) start = 1'b0;
            exp_pc    = npc;
            exp_count = exp_count + 1'b1;
            prev_d    = d;
        end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || pc_addr !== exp_pc || instr_count !== exp_count) begin
            fails++; $display("FAIL free_run_stop: got busy=%b pc=%h cnt=%0d expected 0 %h %0d",
                              busy, pc_addr, instr_count, exp_pc, exp_count);
        end
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        start = 1'b1;
        wait_run(seen);
        #2 rst_n = 1'b0;
        #1;
        total++; if (pc_addr !== 8'h00 || cpu_run !== 1'b0 || busy !== 1'b0 || instr_count !== 16'h0) begin
            fails++; $display("FAIL reset_mid_run: got pc=%h run=%b busy=%b cnt=%0d expected 00 0 0 0",
                              pc_addr, cpu_run, busy, instr_count);
        end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_pc = 8'h00; exp_count = 16'h0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || halted !== 1'b0 || cpu_run !== 1'b0) begin
            fails++; $display("FAIL reset_release_idle: got busy=%b halted=%b run=%b expected 0 0 0", busy, halted, cpu_run);
        end
    endtask

    task automatic test_single_step;
        bit seen;
        int pulses = 0;
        step_mode = 1'b1; start = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) begin
            fails++; $display("FAIL step_start_ignored: got busy=%b expected 0", busy);
        end
        for (int k = 0; k < 3; k++) begin
            step = 1'b1; @(negedge clk); step = 1'b0;
            wait_run(seen);
            if (seen) pulses++;
            total++; if (pc_addr !== exp_pc) begin
                fails++; $display("FAIL step_pc: got %h expected %h", pc_addr, exp_pc);
            end
            finish_instr(0, exp_pc + 8'd1);
            exp_pc = exp_pc + 8'd1; exp_count = exp_count + 1'b1;
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (cpu_run === 1'b1) pulses++;
            end
            total++; if (busy !== 1'b0) begin
                fails++; $display("FAIL step_idle: got busy=%b expected 0", busy);
            end
        end
        total++; if (pulses != 3) begin
            fails++; $display("FAIL step_pulses: got %0d expected 3", pulses);
        end
        total++; if (pc_addr !== 8'd3 || instr_count !== exp_count) begin
            fails++; $display("FAIL step_final: got pc=%h cnt=%0d expected 03 %0d", pc_addr, instr_count, exp_count);
        end
        step_mode = 1'b0; start = 1'b0;
    endtask

    task automatic test_branch;
        bit         seen;
        logic [7:0] targets [3];
        targets[0] = 8'hF0; targets[1] = 8'hFF; targets[2] = 8'h00;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_run(seen);
            total++; if (!seen || pc_addr !== exp_pc) begin
                fails++; $display("FAIL branch_pc: got seen=%b pc=%h expected 1 %h", seen, pc_addr, exp_pc);
            end
            finish_instr(0, targets[k]);
            if (k == 2) start = 1'b0;
            exp_pc = targets[k]; exp_count = exp_count + 1'b1;
        end
        repeat (2) @(negedge clk);
        total++; if (pc_addr !== 8'h00 || instr_count !== exp_count) begin
            fails++; $display("FAIL branch_wrap: got pc=%h cnt=%0d expected 00 %0d", pc_addr, instr_count, exp_count);
        end
    endtask

    task automatic test_halt;
        bit seen, extra;
        start = 1'b1; halt_req = 1'b1;
        @(negedge clk);
        total++; if (halted !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL halt_priority: got halted=%b busy=%b expected 1 0", halted, busy);
        end
        extra = 1'b0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (cpu_run === 1'b1) extra = 1'b1; end
        total++; if (extra) begin fails++; $display("FAIL halt_no_run: got cpu_run=1 expected 0"); end
        halt_req = 1'b0;
        wait_run(seen);
        total++; if (!seen || pc_addr !== exp_pc) begin
            fails++; $display("FAIL halt_release: got seen=%b pc=%h expected 1 %h", seen, pc_addr, exp_pc);
        end
        halt_req = 1'b1;
        finish_instr(1, 8'h42);
        exp_pc = 8'h42; exp_count = exp_count + 1'b1;
        @(negedge clk);
        total++; if (halted !== 1'b1 || busy !== 1'b0 || instr_count !== exp_count || pc_addr !== exp_pc) begin
            fails++; $display("FAIL halt_retire: got halted=%b busy=%b cnt=%0d pc=%h expected 1 0 %0d %h",
                              halted, busy, instr_count, pc_addr, exp_count, exp_pc);
        end
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (cpu_run === 1'b1) extra = 1'b1; end
        total++; if (extra) begin fails++; $display("FAIL halt_hold: got cpu_run=1 expected 0"); end
        halt_req = 1'b0;
        wait_run(seen);
        total++; if (!seen || pc_addr !== 8'h42 || halted !== 1'b0) begin
            fails++; $display("FAIL halt_resume: got seen=%b pc=%h halted=%b expected 1 42 0", seen, pc_addr, halted);
        end
        finish_instr(0, 8'h43);
        start = 1'b0;
        exp_pc = 8'h43; exp_count = exp_count + 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_watchdog;
        bit seen;
        start = 1'b1;
        wait_run(seen);
        finish_instr(4, 8'h10);
        exp_pc = 8'h10; exp_count = exp_count + 1'b1;
        total++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL wdog_tie: got err=%b busy=%b expected 0 1", timeout_err, busy);
        end
        wait_run(seen);
        start = 1'b0;
        total++; if (!seen || pc_addr !== exp_pc || instr_count !== exp_count) begin
            fails++; $display("FAIL wdog_tie_retire: got seen=%b pc=%h cnt=%0d expected 1 %h %0d",
                              seen, pc_addr, instr_count, exp_pc, exp_count);
        end
        repeat (5) @(negedge clk);
        total++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL wdog_exec5: got err=%b busy=%b expected 0 1", timeout_err, busy);
        end
        @(negedge clk);
        total++; if (timeout_err !== 1'b1 || busy !== 1'b0 || halted !== 1'b0) begin
            fails++; $display("FAIL wdog_expire: got err=%b busy=%b halted=%b expected 1 0 0", timeout_err, busy, halted);
        end
        cpu_done = 1'b1; new_pc_in = 8'h77;
        @(negedge clk); cpu_done = 1'b0;
        @(negedge clk);
        total++; if (timeout_err !== 1'b1 || busy !== 1'b0 || cpu_run !== 1'b0 ||
                     pc_addr !== exp_pc || instr_count !== exp_count) begin
            fails++; $display("FAIL wdog_late_done: got err=%b busy=%b run=%b pc=%h cnt=%0d expected 1 0 0 %h %0d",
                              timeout_err, busy, cpu_run, pc_addr, instr_count, exp_pc, exp_count);
        end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        total++; if (timeout_err !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
            fails++; $display("FAIL wdog_clear: got err=%b busy=%b halted=%b expected 0 0 0", timeout_err, busy, halted);
        end
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || pc_addr !== exp_pc) begin
            fails++; $display("FAIL wdog_idle: got busy=%b pc=%h expected 0 %h", busy, pc_addr, exp_pc);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        halt_req = 1'b0; clr_err = 1'b0; cpu_done = 1'b0; new_pc_in = 8'h00;
        exp_pc = 8'h00; exp_count = 16'h0;
        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        imem[0] = 16'h1234;
        test_reset;
        test_free_run;
        test_reset_mid_run;
        test_single_step;
        test_branch;
        test_halt;
        test_watchdog;
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
